// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: funcSel encodings, issue FSM states
// and the default datapath width.
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    localparam logic [2:0] FUNC_ADD = 3'b000;
    localparam logic [2:0] FUNC_XOR = 3'b001;
    localparam logic [2:0] FUNC_AND = 3'b010;
    localparam logic [2:0] FUNC_OR  = 3'b011;
    localparam logic [2:0] FUNC_NOR = 3'b100;
    localparam logic [2:0] FUNC_SHR = 3'b101;
    localparam logic [2:0] FUNC_SHL = 3'b110;
    localparam logic [2:0] FUNC_DIS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_HOLD = 2'd3
    } issue_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue stage: synchronous write, head always visible on
// rd_data, asynchronous active-low reset of pointers and count.
module alu_cmd_fifo #(
    parameter int WIDTH = 67,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers are exactly log2(DEPTH) bits, so they wrap without a compare.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage for the 32-bit ALU: queues commands, parks funcSel at DIS while new
// operands settle, then applies the opcode and returns the captured result.
// Optional macro ALU_ISSUE_ZERO_FLAG_EN adds the resZero output.
//
//   state   | meaning
//   IDLE    | waiting for a queued command
//   LOAD    | operands driven, funcSel parked at DIS
//   EXEC    | funcSel = opcode, counting down SETTLE_CYCLES
//   HOLD    | result presented, waiting for resReady
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W        = ALU_DATA_W,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic [DATA_W-1:0] cmdOperand0,
    input  logic [DATA_W-1:0] cmdOperand1,
    input  logic [2:0]        cmdFuncSel,
    output logic [DATA_W-1:0] aluOperand0,
    output logic [DATA_W-1:0] aluOperand1,
    output logic [2:0]        aluFuncSel,
    input  logic [DATA_W-1:0] aluOut,
    output logic              resValid,
    input  logic              resReady,
    output logic [DATA_W-1:0] resData,
    output logic [2:0]        resFunc,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    output logic              resZero,
`endif
    output logic              busy
);

    localparam int         CMD_W       = 2*DATA_W + 3;
    localparam int         CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    issue_state_e      state;
    logic [2:0]        cur_func;
    logic [3:0]        settle_cnt;

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [CMD_W-1:0]  head;
    logic [DATA_W-1:0] head_op0;
    logic [DATA_W-1:0] head_op1;
    logic [2:0]        head_func;

    assign cmdReady = resetN && !full;
    assign push     = cmdValid && cmdReady;

    assign head_op0  = head[CMD_W-1 -: DATA_W];
    assign head_op1  = head[DATA_W+2 : 3];
    assign head_func = head[2:0];

    // Every state that can hand off to LOAD pops the head on the same edge.
    assign pop = !empty && ((state == ST_IDLE) ||
                            (state == ST_LOAD && cur_func == FUNC_DIS) ||
                            (state == ST_HOLD && resReady));

    assign busy = (count != '0) || (state != ST_IDLE);

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetN  (resetN),
        .push    (push),
        .pop     (pop),
        .wr_data ({cmdOperand0, cmdOperand1, cmdFuncSel}),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= ST_IDLE;
            cur_func    <= FUNC_DIS;
            settle_cnt  <= '0;
            aluOperand0 <= '0;
            aluOperand1 <= '0;
            aluFuncSel  <= FUNC_DIS;
            resValid    <= 1'b0;
            resData     <= '0;
            resFunc     <= '0;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            resZero     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (cur_func == FUNC_DIS) begin
                        state <= empty ? ST_IDLE : ST_LOAD;
                    end else begin
                        aluFuncSel <= cur_func;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (settle_cnt == '0) begin
                        resData  <= aluOut;
                        resFunc  <= cur_func;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
                        resZero  <= (aluOut == '0);
`endif
                        resValid <= 1'b1;
                        state    <= ST_HOLD;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (resReady) begin
                        resValid <= 1'b0;
                        if (empty) begin
                            aluFuncSel <= FUNC_DIS;
                            state      <= ST_IDLE;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // The popped command goes out with funcSel parked so the ALU sees a change.
            if (pop) begin
                aluOperand0 <= head_op0;
                aluOperand1 <= head_op1;
                aluFuncSel  <= FUNC_DIS;
                cur_func    <= head_func;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with an ALU model that only re-evaluates on
// a funcSel change. Zero-flag checks build with ALU_ISSUE_ZERO_FLAG_EN.
`timescale 1ns/1ps
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [31:0] cmdOperand0 = '0;
    logic [31:0] cmdOperand1 = '0;
    logic [2:0]  cmdFuncSel = '0;
    logic [31:0] aluOperand0;
    logic [31:0] aluOperand1;
    logic [2:0]  aluFuncSel;
    logic [31:0] aluOut = '0;
    logic        resValid;
    logic        resReady = 1'b0;
    logic [31:0] resData;
    logic [2:0]  resFunc;
    logic        busy;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic        resZero;
`endif

    typedef struct packed {
        logic [2:0]  func;
        logic [31:0] data;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   n_accepted = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(
        .DATA_W        (32),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .SETTLE_CYCLES (1)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .cmdValid    (cmdValid),
        .cmdReady    (cmdReady),
        .cmdOperand0 (cmdOperand0),
        .cmdOperand1 (cmdOperand1),
        .cmdFuncSel  (cmdFuncSel),
        .aluOperand0 (aluOperand0),
        .aluOperand1 (aluOperand1),
        .aluFuncSel  (aluFuncSel),
        .aluOut      (aluOut),
        .resValid    (resValid),
        .resReady    (resReady),
        .resData     (resData),
        .resFunc     (resFunc),
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        .resZero     (resZero),
`endif
        .busy        (busy)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f);
        case (f)
            FUNC_ADD: return a + b;
            FUNC_XOR: return a ^ b;
            FUNC_AND: return a & b;
            FUNC_OR:  return a | b;
            FUNC_NOR: return ~(a | b);
            FUNC_SHR: return a >> b[4:0];
            FUNC_SHL: return a << b[4:0];
            default:  return 32'h0;
        endcase
    endfunction

    // Real ALU behaviour: output only recomputes when funcSel changes to an opcode.
    always @(aluFuncSel) begin
        if (aluFuncSel != FUNC_DIS) aluOut = alu_ref(aluOperand0, aluOperand1, aluFuncSel);
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic rdy;
        int   n;
        exp_t e;
        n = 0;
        cmdValid = 1'b1;
        cmdOperand0 = a;
        cmdOperand1 = b;
        cmdFuncSel = f;
        do begin
            rdy = cmdReady;
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!rdy && n < 200);
        cmdValid = 1'b0;
        total++;
        if (!rdy) begin
            bad++;
            $display("FAIL send_timeout: cmdReady=%0b, required 1 within 200 cycles", cmdReady);
        end else begin
            n_accepted++;
            if (f != FUNC_DIS) begin
                e.func = f;
                e.data = alu_ref(a, b, f);
                e.zero = (e.data == 32'h0);
                sb.push_back(e);
            end
        end
    endtask

    task automatic drain(input int n, input int budget);
        int   got;
        int   cyc;
        exp_t e;
        got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            if (resValid && resReady) begin
                got++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL result_unexpected: resData=%h resFunc=%b, no result required", resData, resFunc);
                end else begin
                    e = sb.pop_front();
                    if (resData !== e.data || resFunc !== e.func) begin
                        bad++;
                        $display("FAIL result_data: got %h/%b, required %h/%b", resData, resFunc, e.data, e.func);
                    end
`ifdef ALU_ISSUE_ZERO_FLAG_EN
                    total++;
                    if (resZero !== e.zero) begin
                        bad++;
                        $display("FAIL result_zero: got %0b, required %0b", resZero, e.zero);
                    end
`endif
                end
            end
            @(negedge clk);
            cyc++;
        end
        total++;
        if (got < n) begin
            bad++;
            $display("FAIL drain_timeout: got %0d results, required %0d", got, n);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (aluOperand0 !== 32'h0 || aluOperand1 !== 32'h0 || aluFuncSel !== 3'b111) begin
            bad++;
            $display("FAIL reset_alu: got %h %h %b, required 0 0 111", aluOperand0, aluOperand1, aluFuncSel);
        end
        total++;
        if (resValid !== 1'b0 || resData !== 32'h0 || resFunc !== 3'b000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_res: got v=%0b d=%h f=%b busy=%0b, required 0 0 000 0", resValid, resData, resFunc, busy);
        end
        total++;
        if (cmdReady !== 1'b0) begin
            bad++;
            $display("FAIL reset_cmdready: got %0b, required 0", cmdReady);
        end
        resetN = 1'b1;
        @(negedge clk);
        total++;
        if (cmdReady !== 1'b1) begin
            bad++;
            $display("FAIL release_cmdready: got %0b, required 1", cmdReady);
        end
    endtask

    task automatic test_single_add();
        resReady = 1'b1;
        cmdValid = 1'b1;
        cmdOperand0 = 32'h5;
        cmdOperand1 = 32'h3;
        cmdFuncSel = FUNC_ADD;
        @(posedge clk);
        @(negedge clk);
        cmdValid = 1'b0;
        total++;
        if (aluFuncSel !== 3'b111 || resValid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL add_edge1: got sel=%b v=%0b busy=%0b, required 111 0 1", aluFuncSel, resValid, busy);
        end
        @(negedge clk);
        total++;
        if (aluOperand0 !== 32'h5 || aluOperand1 !== 32'h3 || aluFuncSel !== 3'b111) begin
            bad++;
            $display("FAIL add_load: got %h %h %b, required 5 3 111", aluOperand0, aluOperand1, aluFuncSel);
        end
        @(negedge clk);
        total++;
        if (aluFuncSel !== FUNC_ADD || resValid !== 1'b0) begin
            bad++;
            $display("FAIL add_exec: got sel=%b v=%0b, required 000 0", aluFuncSel, resValid);
        end
        @(negedge clk);
        total++;
        if (resValid !== 1'b1 || resData !== 32'h8 || resFunc !== FUNC_ADD) begin
            bad++;
            $display("FAIL add_result: got v=%0b d=%h f=%b, required 1 00000008 000", resValid, resData, resFunc);
        end
        @(negedge clk);
        total++;
        if (resValid !== 1'b0 || aluFuncSel !== 3'b111 || busy !== 1'b0) begin
            bad++;
            $display("FAIL add_idle: got v=%0b sel=%b busy=%0b, required 0 111 0", resValid, aluFuncSel, busy);
        end
    endtask

    task automatic test_repeat_opcode();
        int         rises;
        int         cyc;
        logic [2:0] prev;
        rises = 0;
        cyc = 0;
        prev = FUNC_DIS;
        resReady = 1'b1;
        fork
            begin
                send(32'hFFFF0000, 32'h0F0F0F0F, FUNC_AND);
                send(32'h12345678, 32'hFFFFFFFF, FUNC_AND);
            end
            drain(2, 50);
            begin
                while (cyc < 20) begin
                    @(negedge clk);
                    cyc++;
                    if (aluFuncSel == FUNC_AND && prev != FUNC_AND) rises++;
                    prev = aluFuncSel;
                end
            end
        join
        total++;
        if (rises != 2) begin
            bad++;
            $display("FAIL repeat_park: got %0d transitions into AND, required 2", rises);
        end
        total++;
        if (resData !== 32'h12345678) begin
            bad++;
            $display("FAIL repeat_last: got %h, required 12345678", resData);
        end
    endtask

    task automatic test_back_to_back();
        int stamp[$];
        int cyc;
        cyc = 0;
        resReady = 1'b1;
        fork
            begin
                send(32'h1, 32'h2, FUNC_ADD);
                send(32'h3, 32'h4, FUNC_XOR);
                send(32'hF0, 32'h3C, FUNC_OR);
                send(32'hFFFF0000, 32'h4, FUNC_SHR);
            end
            drain(4, 100);
            begin
                while (stamp.size() < 4 && cyc < 100) begin
                    @(negedge clk);
                    cyc++;
                    if (resValid) stamp.push_back(cyc);
                end
            end
        join
        total++;
        if (stamp.size() != 4) begin
            bad++;
            $display("FAIL b2b_count: got %0d results, required 4", stamp.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                total++;
                if (stamp[i] - stamp[i-1] != 3) begin
                    bad++;
                    $display("FAIL b2b_gap: got %0d cycles, required 3", stamp[i] - stamp[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        base = n_accepted;
        resReady = 1'b0;
        fork
            for (int i = 0; i < 6; i++) send(32'(256*i + 1), 32'(i), 3'(i));
            begin
                repeat (8) @(negedge clk);
                total++;
                if (n_accepted - base != FIFO_DEPTH + 1) begin
                    bad++;
                    $display("FAIL full_accepts: got %0d, required %0d", n_accepted - base, FIFO_DEPTH + 1);
                end
                total++;
                if (cmdReady !== 1'b0) begin
                    bad++;
                    $display("FAIL full_cmdready: got %0b, required 0", cmdReady);
                end
                total++;
                if (resValid !== 1'b1 || resData !== 32'h1) begin
                    bad++;
                    $display("FAIL full_first: got v=%0b d=%h, required 1 00000001", resValid, resData);
                end
                @(negedge clk);
                total++;
                if (resData !== 32'h1 || resFunc !== FUNC_ADD) begin
                    bad++;
                    $display("FAIL full_hold: got %h/%b, required 00000001/000", resData, resFunc);
                end
                resReady = 1'b1;
                drain(6, 100);
            end
        join
    endtask

    task automatic test_nop();
        int extra;
        extra = 0;
        resReady = 1'b1;
        fork
            begin
                send(32'h1, 32'h2, FUNC_OR);
                send(32'h5, 32'h6, FUNC_DIS);
                send(32'h0, 32'h0, FUNC_NOR);
            end
            drain(2, 60);
        join
        repeat (10) begin
            @(negedge clk);
            if (resValid) extra++;
        end
        total++;
        if (extra != 0 || sb.size() != 0) begin
            bad++;
            $display("FAIL nop_extra: got %0d extra cycles, %0d pending, required 0 0", extra, sb.size());
        end
        total++;
        if (resData !== 32'hFFFFFFFF || busy !== 1'b0) begin
            bad++;
            $display("FAIL nop_last: got %h busy=%0b, required ffffffff 0", resData, busy);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int late;
        cyc = 0;
        late = 0;
        resReady = 1'b1;
        send(32'h80000001, 32'h1, FUNC_SHL);
        send(32'h7, 32'h7, FUNC_ADD);
        while (aluFuncSel !== FUNC_SHL && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (aluFuncSel !== FUNC_SHL) begin
            bad++;
            $display("FAIL mid_reach_exec: got sel=%b, required 110", aluFuncSel);
        end
        resetN = 1'b0;
        #1;
        total++;
        if (aluOperand0 !== 32'h0 || aluOperand1 !== 32'h0 || aluFuncSel !== 3'b111) begin
            bad++;
            $display("FAIL mid_alu: got %h %h %b, required 0 0 111", aluOperand0, aluOperand1, aluFuncSel);
        end
        total++;
        if (resValid !== 1'b0 || resData !== 32'h0 || busy !== 1'b0 || cmdReady !== 1'b0) begin
            bad++;
            $display("FAIL mid_res: got v=%0b d=%h busy=%0b rdy=%0b, required 0 0 0 0", resValid, resData, busy, cmdReady);
        end
        sb.delete();
        @(negedge clk);
        resetN = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (resValid || busy) late++;
        end
        total++;
        if (late != 0) begin
            bad++;
            $display("FAIL mid_discard: got %0d active cycles after release, required 0", late);
        end
        send(32'h80000001, 32'h1, FUNC_SHR);
        drain(1, 20);
        total++;
        if (resData !== 32'h40000000) begin
            bad++;
            $display("FAIL mid_fresh: got %h, required 40000000", resData);
        end
    endtask

    task automatic test_zero_flag();
        int cyc;
        resReady = 1'b0;
        send(32'hA5A5A5A5, 32'hA5A5A5A5, FUNC_XOR);
        cyc = 0;
        while (!resValid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (resValid !== 1'b1 || resData !== 32'h0 || resFunc !== FUNC_XOR) begin
            bad++;
            $display("FAIL zero_xor: got v=%0b d=%h f=%b, required 1 00000000 001", resValid, resData, resFunc);
        end
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        total++;
        if (resZero !== 1'b1) begin
            bad++;
            $display("FAIL zero_flag_set: got %0b, required 1", resZero);
        end
`endif
        resReady = 1'b1;
        drain(1, 10);
        resReady = 1'b0;
        send(32'h1, 32'h0, FUNC_ADD);
        cyc = 0;
        while (!resValid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (resValid !== 1'b1 || resData !== 32'h1) begin
            bad++;
            $display("FAIL zero_add: got v=%0b d=%h, required 1 00000001", resValid, resData);
        end
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        total++;
        if (resZero !== 1'b0) begin
            bad++;
            $display("FAIL zero_flag_clear: got %0b, required 0", resZero);
        end
`endif
        resReady = 1'b1;
        drain(1, 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_add();
        test_repeat_opcode();
        test_back_to_back();
        test_backpressure();
        test_nop();
        test_reset_mid();
        test_zero_flag();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream issue stage for the 32-bit ALU; buffers operation commands and drives the ALU operand and function-select inputs.
- The ALU re-evaluates only when its function select changes. This block therefore presents new operands with funcSel parked at 3'b111 (disable) for one cycle, then applies the real funcSel.
- Captures the ALU result and returns it through a valid/ready result port.

Parameters:
- DATA_W, 32: operand and result width.
- FIFO_DEPTH, 4: command FIFO entries; power of 2, minimum 2.
- SETTLE_CYCLES, 1: cycles funcSel is held before the result is captured; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- cmdValid  in  1  command offered.
- cmdReady  out  1  command FIFO can accept.
- cmdOperand0  in  DATA_W  first operand.
- cmdOperand1  in  DATA_W  second operand.
- cmdFuncSel  in  3  ALU operation code.
- aluOperand0  out  DATA_W  to ALU operand0.
- aluOperand1  out  DATA_W  to ALU operand1.
- aluFuncSel  out  3  to ALU funcSel.
- aluOut  in  DATA_W  from ALU out.
- resValid  out  1  result available.
- resReady  in  1  consumer accepts result.
- resData  out  DATA_W  captured result.
- resFunc  out  3  opcode that produced resData.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (resetN low, asynchronous): FIFO emptied, FSM to IDLE.
  - aluOperand0/1 = 0, aluFuncSel = 3'b111.
  - resValid = 0, resData = 0, resFunc = 0, busy = 0.
  - cmdReady is forced 0 while resetN is low.
- Reset mid-operation discards all queued and in-flight commands; no result is produced for them.
- Command push: a command is written when cmdValid && cmdReady at a rising edge. cmdReady = !full.
  - Push and pop in the same cycle are both legal; count is unchanged.
  - A command offered while full is not accepted, and cmdValid/data must be held by the source.
- FSM states: IDLE, LOAD, EXEC, HOLD.
  - IDLE: if FIFO non-empty, pop the head and go to LOAD.
  - LOAD (1 cycle): aluOperand0/1 take the popped operands; aluFuncSel = 3'b111.
    - If the popped funcSel is 3'b111 (NOP), go to IDLE with no result, or straight to LOAD if the FIFO is non-empty.
    - Otherwise go to EXEC.
  - EXEC: aluFuncSel = popped opcode, held for SETTLE_CYCLES via a down-counter.
    - On the last cycle, resData <= aluOut and resFunc <= opcode at the clock edge; resValid goes 1; go to HOLD.
  - HOLD: resValid = 1; resData, resFunc, aluOperand* and aluFuncSel are all held stable.
    - On resReady: resValid goes 0. Go to LOAD (popping the FIFO) if it is non-empty, else go to IDLE and park aluFuncSel at 3'b111.
- Latency (SETTLE_CYCLES=1, empty pipe): command accepted at edge T → popped at edge T+1 → LOAD → EXEC → resValid high after edge T+3.
  - Back-to-back throughput: one result per 3 cycles with resReady tied high.
- Opcodes 000..110 are passed through unchanged. The ALU zero-extends shift results; no width conversion is done here.
- Identical consecutive opcodes still produce the 111→op transition in LOAD, so every command re-evaluates the ALU.
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap naturally; the count is log2(FIFO_DEPTH)+1 bits wide.

Optional Feature:
- Macro: ALU_ISSUE_ZERO_FLAG_EN.
- With the macro defined: an extra output port resZero (1 bit), registered alongside resData, equal to (aluOut == 0) at capture. Reset value 0; held in HOLD.
- Without the macro: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - funcSel encodings FUNC_ADD=000, FUNC_XOR=001, FUNC_AND=010, FUNC_OR=011, FUNC_NOR=100, FUNC_SHR=101, FUNC_SHL=110, FUNC_DIS=111.
  - Issue FSM state enum.
  - ALU_DATA_W=32.
- One sub-module: alu_cmd_fifo.
  - Synchronous-write FIFO, width 2*DATA_W+3, depth FIFO_DEPTH, with push/pop/full/empty/count and asynchronous active-low reset.

Test Plan:
- Single ADD: push (0x00000005, 0x00000003, 000) with resReady=1 → aluFuncSel 111 then 000; resValid after 4th edge; resData=0x00000008, resFunc=000.
- Repeated opcode: push AND(0xFFFF0000,0x0F0F0F0F), then AND(0x12345678,0xFFFFFFFF) → results 0x0F0F0000 then 0x12345678; aluFuncSel returns to 111 between the two.
- Backpressure/full: resReady=0, push 6 commands back-to-back → cmdReady drops after FIFO_DEPTH+1 accepts; resData stays at the first result. Releasing resReady drains the rest in order.
- NOP: push OR(1,2), DIS(x,x), NOR(0,0) → exactly two results, 0x00000003 then 0xFFFFFFFF.
- Reset mid-EXEC: drop resetN during EXEC of SHL(0x80000001) → outputs go to reset values immediately and the FIFO is empty. After release, a fresh SHR(0x80000001) yields 0x40000000.
- Zero flag (ALU_ISSUE_ZERO_FLAG_EN): XOR(0xA5A5A5A5,0xA5A5A5A5) → resData=0, resZero=1. ADD(1,0) → resZero=0.
